// File: rtl/alu_operand_loader.sv
// alu_operand_loader: serial operand front end for the 8-bit ALU.
// Synchronises the ld_stb pin, captures A, B and the 2-bit opcode from ui_in
// on successive strobe rises, issues the operation, then registers the result.
// A watchdog drops a half-loaded operation if the host stops strobing.
module alu_operand_loader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic       ld_stb,
  input  logic [7:0] alu_result,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic [1:0] op_out,
  output logic       issue,
  output logic [7:0] result_out,
  output logic       result_valid,
  output logic       busy,
  output logic       timeout,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_ISSUE   = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0]         sync_q;
  logic                           prev_q;
  logic [SYNC_STAGES-1:0][7:0]    ui_pipe_q;
  logic [7:0]                     a_q, a_d;
  logic [7:0]                     b_q, b_d;
  logic [1:0]                     op_q, op_d;
  logic [7:0]                     res_q, res_d;
  logic                           rv_q, rv_d;
  logic [TIMEOUT_W-1:0]           wd_q, wd_d;
  logic                           tmo;

  logic       sync_out;
  logic       stb_rise;
  logic [7:0] ui_d;
  logic       wd_term;
  logic       in_load_bo;

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign stb_rise   = sync_out & ~prev_q;
  // Delayed by the same depth as the strobe, so ui_d is the bus value seen
  // on the edge that first sampled the strobe high.
  assign ui_d       = ui_pipe_q[SYNC_STAGES-1];
  assign wd_term    = (wd_q == '1);
  assign in_load_bo = (state_q == S_LOAD_B) || (state_q == S_LOAD_OP);

  // Strobe synchroniser, edge-detect history and matching data pipeline;
  // these run regardless of ena so a disabled-time edge is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      ui_pipe_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ld_stb};
      prev_q    <= sync_out;
      ui_pipe_q <= {ui_pipe_q[SYNC_STAGES-2:0], ui_in};
    end
  end

  // Next-state, capture and watchdog logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    rv_d    = rv_q;
    tmo     = 1'b0;
    if (ena) begin
      case (state_q)
        S_LOAD_A: begin
          if (stb_rise) begin
            a_d     = ui_d;
            rv_d    = 1'b0;
            state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (stb_rise) begin
            b_d     = ui_d;
            state_d = S_LOAD_OP;
          end else if (wd_term) begin
            tmo     = 1'b1;
            state_d = S_LOAD_A;
          end
        end
        S_LOAD_OP: begin
          if (stb_rise) begin
            op_d    = ui_d[1:0];
            state_d = S_ISSUE;
          end else if (wd_term) begin
            tmo     = 1'b1;
            state_d = S_LOAD_A;
          end
        end
        S_ISSUE: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          res_d   = alu_result;
          rv_d    = 1'b1;
          state_d = S_LOAD_A;
        end
        default: begin
          state_d = S_LOAD_A;
        end
      endcase
    end

    wd_d = wd_q;
    if (ena) begin
      if (stb_rise || (state_d != state_q) || !in_load_bo) begin
        wd_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  // State, operand, result and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      wd_q    <= wd_d;
    end
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign op_out       = op_q;
  assign result_out   = res_q;
  assign result_valid = rv_q;
  assign issue        = ena && (state_q == S_ISSUE);
  assign timeout      = tmo;
  assign busy         = (state_q == S_LOAD_B) || (state_q == S_LOAD_OP) ||
                        (state_q == S_ISSUE)  || (state_q == S_CAPTURE);
  assign state_out    = state_q;

endmodule
